// File: rtl/usb_line_encoder_pkg.sv
// usb_line_encoder_pkg: shared line/encoder state enums, default SYNC/stuff/EOP lengths, J/K/SE0 pin encodings
package usb_line_encoder_pkg;
  typedef enum logic [1:0] {LS_J, LS_K, LS_SE0} line_state_t;
  typedef enum logic [2:0] {S_IDLE, S_SYNC, S_DATA, S_STUFF, S_EOP_SE0, S_EOP_J} enc_state_t;
  localparam int USB_SYNC_LEN = 8;
  localparam int USB_STUFF_LIMIT = 6;
  localparam int USB_EOP_SE0 = 2;
  localparam logic [1:0] PINS_J = 2'b10;
  localparam logic [1:0] PINS_K = 2'b01;
  localparam logic [1:0] PINS_SE0 = 2'b00;
  function automatic line_state_t nrzi_toggle(input line_state_t l);
    return l == LS_J ? LS_K : LS_J;
  endfunction
  function automatic logic [1:0] line_pins(input line_state_t l);
    return l == LS_J ? PINS_J : l == LS_K ? PINS_K : PINS_SE0;
  endfunction
endpackage

// File: rtl/usb_line_encoder_if.sv
// usb_line_encoder_if: upstream bit stream (bit_in, sending, pause) plus line pins (dp, dm, oe) and busy; master = source side, slave = encoder
interface usb_line_encoder_if;
  logic bit_in;
  logic sending;
  logic pause;
  logic dp;
  logic dm;
  logic oe;
  logic busy;
  modport master(output bit_in, sending, input pause, dp, dm, oe, busy);
  modport slave(input bit_in, sending, output pause, dp, dm, oe, busy);
endinterface

// File: rtl/usb_line_encoder_counter.sv
// usb_line_encoder_counter: W-bit phase counter; clk, rst, clr (priority), en in; q out
module usb_line_encoder_counter #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         en,
  output logic [W-1:0] q
);
  logic [W-1:0] q_q, q_d;
  always_comb q_d = clr ? '0 : en ? q_q + W'(1) : q_q;
  always_ff @(posedge clk) q_q <= rst ? '0 : q_d;
  assign q = q_q;
endmodule

// File: rtl/usb_line_encoder.sv
// usb_line_encoder: SYNC + bit stuffing + NRZI + EOP line stage; clk, rst in; bus.slave: bit_in, sending in; pause, dp, dm, oe (registered), busy out
module usb_line_encoder
  import usb_line_encoder_pkg::*;
#(
  parameter int SYNC_LEN = USB_SYNC_LEN,
  parameter int STUFF_LIMIT = USB_STUFF_LIMIT,
  parameter int EOP_SE0 = USB_EOP_SE0
) (
  input logic clk,
  input logic rst,
  usb_line_encoder_if.slave bus
);
  localparam int OW = $clog2(STUFF_LIMIT + 1);
  localparam int CW = $clog2((SYNC_LEN > EOP_SE0 ? SYNC_LEN : EOP_SE0) + 1);
  enc_state_t state_q, state_d;
  line_state_t lvl_q, lvl_d, line;
  logic [OW-1:0] ones_q, ones_d;
  logic [CW-1:0] cnt;
  logic cnt_clr, cnt_en, sync_last, eop_last;
  logic dp_q, dp_d, dm_q, dm_d, oe_q, oe_d;
  usb_line_encoder_counter #(.W(CW)) u_cnt (.clk, .rst, .clr(cnt_clr), .en(cnt_en), .q(cnt));
  assign sync_last = cnt == CW'(SYNC_LEN - 1);
  assign eop_last = cnt == CW'(EOP_SE0 - 1);
  always_comb begin
    state_d = state_q;
    ones_d = ones_q;
    lvl_d = lvl_q;
    line = lvl_q;
    oe_d = 1'b1;
    cnt_clr = 1'b0;
    cnt_en = 1'b0;
    case (state_q)
      S_IDLE: begin
        lvl_d = LS_J;
        line = LS_J;
        oe_d = 1'b0;
        ones_d = '0;
        cnt_clr = 1'b1;
        state_d = bus.sending ? S_SYNC : S_IDLE;
      end
      S_SYNC: begin
        lvl_d = sync_last ? lvl_q : nrzi_toggle(lvl_q);
        line = lvl_d;
        cnt_en = 1'b1;
        cnt_clr = sync_last;
        ones_d = sync_last ? OW'(1) : '0;
        state_d = sync_last ? S_DATA : S_SYNC;
      end
      S_DATA: begin
        // a DATA cycle with no bit already drives the first SE0, so the EOP counter starts at 1
        if (!bus.sending) begin
          line = LS_SE0;
          cnt_en = 1'b1;
          state_d = EOP_SE0 > 1 ? S_EOP_SE0 : S_EOP_J;
        end else begin
          lvl_d = bus.bit_in ? lvl_q : nrzi_toggle(lvl_q);
          line = lvl_d;
          ones_d = bus.bit_in ? ones_q + OW'(1) : '0;
          state_d = bus.bit_in && ones_q == OW'(STUFF_LIMIT - 1) ? S_STUFF : S_DATA;
        end
      end
      S_STUFF: begin
        lvl_d = nrzi_toggle(lvl_q);
        line = lvl_d;
        ones_d = '0;
        state_d = bus.sending ? S_DATA : S_EOP_SE0;
      end
      S_EOP_SE0: begin
        line = LS_SE0;
        cnt_en = 1'b1;
        state_d = eop_last ? S_EOP_J : S_EOP_SE0;
      end
      S_EOP_J: begin
        lvl_d = LS_J;
        line = LS_J;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    {dp_d, dm_d} = line_pins(line);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      ones_q <= '0;
      lvl_q <= LS_J;
      dp_q <= 1'b1;
      dm_q <= 1'b0;
      oe_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ones_q <= ones_d;
      lvl_q <= lvl_d;
      dp_q <= dp_d;
      dm_q <= dm_d;
      oe_q <= oe_d;
    end
  end
  assign bus.pause = state_q != S_DATA;
  assign bus.busy = state_q != S_IDLE;
  assign bus.dp = dp_q;
  assign bus.dm = dm_q;
  assign bus.oe = oe_q;
endmodule

// File: tb/tb_usb_line_encoder.sv
// tb_usb_line_encoder: directed packets checked cycle by cycle against a bit-level wire model
module tb_usb_line_encoder;
  localparam logic [2:0] J0 = 3'b100, J1 = 3'b101, K1 = 3'b011, S1 = 3'b001;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  usb_line_encoder_if bus();
  usb_line_encoder dut (.clk(clk), .rst(rst), .bus(bus));
  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;
  logic [2:0] exp_q[$];
  logic [2:0] mdl_q[$];
  bit cons_log[$];
  bit pay[$];
  logic [2:0] lit [0:20];
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", nm, act, exp, $time);
    end
  endtask
  task automatic model();
    bit b[$];
    bit s[$];
    int ones;
    bit lvl;
    ones = 0;
    lvl = 1'b1;
    mdl_q.delete();
    for (int i = 0; i < 8; i++) b.push_back(i == 7);
    foreach (pay[i]) b.push_back(pay[i]);
    foreach (b[i]) begin
      s.push_back(b[i]);
      ones = b[i] ? ones + 1 : 0;
      if (ones == 6) begin
        s.push_back(1'b0);
        ones = 0;
      end
    end
    foreach (s[i]) begin
      if (!s[i]) lvl = !lvl;
      mdl_q.push_back(lvl ? J1 : K1);
    end
    mdl_q.push_back(S1);
    mdl_q.push_back(S1);
    mdl_q.push_back(J1);
  endtask
  always @(posedge clk) if (!rst && bus.sending && !bus.pause) cons_log.push_back(bus.bit_in);
  always @(negedge clk) begin : cmp
    logic [2:0] e;
    if (chk_en) begin
      e = exp_q.size() > 0 ? exp_q.pop_front() : J0;
      chk("line dp/dm/oe", {61'd0, bus.dp, bus.dm, bus.oe}, {61'd0, e});
    end
  end
  task automatic run_pkt(input string nm, input bit cs, input bit ce, input int ab);
    int base;
    int n;
    bit done;
    logic [63:0] a;
    logic [63:0] x;
    model();
    base = cons_log.size();
    n = 0;
    if (!cs) exp_q.push_back(J0);
    exp_q.push_back(J0);
    foreach (mdl_q[i]) exp_q.push_back(mdl_q[i]);
    bus.sending = 1'b1;
    bus.bit_in = pay.size() > 0 ? pay[0] : 1'b0;
    done = 1'b0;
    for (int c = 0; c < 400 && !done; c++) begin
      @(posedge clk);
      #1;
      n = cons_log.size() - base;
      bus.sending = n < pay.size();
      bus.bit_in = n < pay.size() ? pay[n] : 1'b0;
      done = ab >= 0 ? n >= ab : n >= pay.size() && exp_q.size() == (ce ? 2 : 0);
    end
    chk({nm, " done in budget"}, 64'(done), 64'd1);
    chk({nm, " bits consumed"}, 64'(n), ab >= 0 ? 64'(ab) : 64'(pay.size()));
    a = '0;
    x = '0;
    for (int i = 0; i < n && i < 64; i++) begin
      a[i] = cons_log[base + i];
      x[i] = pay[i];
    end
    chk({nm, " consumed values"}, a, x);
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end
  initial begin
    bus.sending = 1'b1;
    bus.bit_in = 1'b1;
    rst = 1'b1;
    @(posedge clk);
    chk_en = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("reset pause", 64'(bus.pause), 64'd1);
    chk("reset busy", 64'(bus.busy), 64'd0);
    chk("reset pins", {61'd0, bus.dp, bus.dm, bus.oe}, {61'd0, J0});
    bus.sending = 1'b0;
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("idle busy", 64'(bus.busy), 64'd0);
    pay = '{0, 1, 0, 0, 1, 0, 1, 1};
    model();
    lit = '{K1, J1, K1, J1, K1, J1, K1, K1, J1, J1, K1, J1, J1, K1, K1, K1, S1, S1, J1, J0, J0};
    chk("ack model length", 64'(mdl_q.size()), 64'd19);
    for (int i = 0; i < 19; i++) chk("ack model symbol", 64'(mdl_q[i]), 64'(lit[i]));
    run_pkt("ack", 1'b0, 1'b0, -1);
    pay = '{1, 1, 1, 1, 1, 1, 1, 0};
    model();
    lit = '{K1, J1, K1, J1, K1, J1, K1, K1, K1, K1, K1, K1, K1, J1, J1, J1, K1, S1, S1, J1, J0};
    chk("stuff model length", 64'(mdl_q.size()), 64'd20);
    for (int i = 0; i < 20; i++) chk("stuff model symbol", 64'(mdl_q[i]), 64'(lit[i]));
    run_pkt("stuff mid", 1'b0, 1'b0, -1);
    pay = '{1, 0, 0, 1, 1, 1, 1, 1, 1};
    model();
    chk("end stuff model length", 64'(mdl_q.size()), 64'd21);
    run_pkt("stuff at end", 1'b0, 1'b0, -1);
    pay = '{0, 1, 1, 0, 1, 0, 0, 1, 1, 1, 0, 1};
    run_pkt("abort", 1'b0, 1'b0, 3);
    chk("busy mid-data", 64'(bus.busy), 64'd1);
    rst = 1'b1;
    bus.sending = 1'b0;
    while (exp_q.size() > 1) void'(exp_q.pop_back());
    @(posedge clk);
    #1;
    chk("abort busy", 64'(bus.busy), 64'd0);
    chk("abort pause", 64'(bus.pause), 64'd1);
    chk("abort pins", {61'd0, bus.dp, bus.dm, bus.oe}, {61'd0, J0});
    rst = 1'b0;
    pay = '{1, 1, 0, 1, 0, 0, 0, 1};
    run_pkt("after abort", 1'b0, 1'b0, -1);
    pay = '{1, 0, 1, 1, 0};
    run_pkt("b2b first", 1'b0, 1'b1, -1);
    chk("b2b eop_j pause", 64'(bus.pause), 64'd1);
    pay = '{1, 1, 1, 0, 0, 1};
    run_pkt("b2b second", 1'b1, 1'b0, -1);
    pay.delete();
    run_pkt("zero payload", 1'b0, 1'b0, -1);
    pay = '{1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1};
    run_pkt("all ones", 1'b0, 1'b0, -1);
    repeat (3) @(posedge clk);
    #1;
    chk("final idle busy", 64'(bus.busy), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
